// File: rtl/cache_line_bridge.sv
// cache_line_bridge: line writeback/refill engine between the OTTER 2-way data cache and word-wide main memory.
// Build macro CACHE_CRITICAL_WORD_FIRST_EN (optional) starts each refill at the requested word and wraps.
module cache_line_bridge #(
  parameter int BEATS  = 8,
  parameter int WORD_W = 32
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wb,
  input  logic                    req_fill,
  input  logic [31:0]             wb_addr,
  input  logic [BEATS*WORD_W-1:0] wb_line,
  input  logic [31:0]             fill_addr,
  output logic                    resp_valid,
  output logic [BEATS*WORD_W-1:0] resp_line,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [31:0]             mem_addr,
  output logic [WORD_W-1:0]       mem_wdata,
  input  logic [WORD_W-1:0]       mem_rdata,
  input  logic                    mem_ack
);

  localparam int CNT_W  = $clog2(BEATS);
  localparam int LINE_W = BEATS * WORD_W;

  typedef enum logic [1:0] {IDLE, WB, FILL, RESP} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [31-CNT_W:0]   wb_hi;
  logic [31-CNT_W:0]   fill_hi;
  logic [CNT_W-1:0]    fill_off;
  logic                fill_pend;
  logic [LINE_W-1:0]   wb_buf;
  logic [LINE_W-1:0]   line_buf;

  logic [CNT_W-1:0]    cnt_nx;
  logic [CNT_W-1:0]    fill_idx;
  logic [CNT_W-1:0]    fill_idx_nx;
  logic [CNT_W-1:0]    fill_start;
  logic                last;
  logic                beat_done;
  logic [LINE_W-1:0]   filled;
  logic                unused_addr_bits;

  function automatic logic [WORD_W-1:0] word_at(input logic [LINE_W-1:0] line,
                                                input logic [CNT_W-1:0]  idx);
    return line[WORD_W*int'(idx) +: WORD_W];
  endfunction

  function automatic logic [LINE_W-1:0] put_word(input logic [LINE_W-1:0] line,
                                                 input logic [CNT_W-1:0]  idx,
                                                 input logic [WORD_W-1:0] w);
    logic [LINE_W-1:0] r;
    r = line;
    r[WORD_W*int'(idx) +: WORD_W] = w;
    return r;
  endfunction

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
  assign fill_start = fill_addr[CNT_W-1:0];
`else
  assign fill_start = '0;
`endif

  // cnt counts acks in the phase; the fill word index is that count rotated by the start offset
  assign cnt_nx      = cnt + CNT_W'(1);
  assign fill_idx    = cnt + fill_off;
  assign fill_idx_nx = cnt_nx + fill_off;
  assign last        = (cnt == CNT_W'(BEATS - 1));
  assign beat_done   = mem_req && mem_ack;
  assign filled      = put_word(line_buf, fill_idx, mem_rdata);

  assign unused_addr_bits = ^{wb_addr[CNT_W-1:0], fill_addr[CNT_W-1:0]};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      resp_line  <= '0;
      cnt        <= '0;
      fill_off   <= '0;
      fill_pend  <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            wb_hi     <= wb_addr[31:CNT_W];
            wb_buf    <= wb_line;
            fill_hi   <= fill_addr[31:CNT_W];
            fill_off  <= fill_start;
            fill_pend <= req_fill;
            req_ready <= 1'b0;
            cnt       <= '0;
            if (req_wb) begin
              state     <= WB;
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= {wb_addr[31:CNT_W], {CNT_W{1'b0}}};
              mem_wdata <= wb_line[WORD_W-1:0];
            end else if (req_fill) begin
              state    <= FILL;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= {fill_addr[31:CNT_W], fill_start};
            end else begin
              state      <= RESP;
              resp_valid <= 1'b1;
            end
          end
        end
        WB: begin
          if (beat_done) begin
            cnt <= cnt_nx;
            if (last) begin
              // mem_req stays high straight into the refill when one is pending
              if (fill_pend) begin
                state    <= FILL;
                mem_we   <= 1'b0;
                mem_addr <= {fill_hi, fill_off};
              end else begin
                state      <= RESP;
                mem_req    <= 1'b0;
                mem_we     <= 1'b0;
                resp_valid <= 1'b1;
              end
            end else begin
              mem_addr  <= {wb_hi, cnt_nx};
              mem_wdata <= word_at(wb_buf, cnt_nx);
            end
          end
        end
        FILL: begin
          if (beat_done) begin
            cnt      <= cnt_nx;
            line_buf <= filled;
            if (last) begin
              state      <= RESP;
              mem_req    <= 1'b0;
              resp_valid <= 1'b1;
              resp_line  <= filled;
            end else begin
              mem_addr <= {fill_hi, fill_idx_nx};
            end
          end
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
